sdvm_pipe: RTL and testbench

Parametrised signed-digit vector multiplexer for the online multiplier datapath. Each cycle it takes a radix-2 signed digit and a redundant (plus/minus) operand vector, delays the digit through a programmable-depth line, and emits the vector scaled by the delayed digit: +X, −X or 0. An iteration counter and a small FSM frame one online multiplication of NUM_DIGITS digits, so downstream accumulators get valid and last flags.

---
 rtl/sd_pkg.sv | 24 ++
 rtl/sd_delay_line.sv | 26 ++
 rtl/sdvm_pipe.sv | 140 ++++++++++++++
 tb/tb_sdvm_pipe.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared types for the signed-digit vector multiplexer: digit encoding,
// delay-line payload and the framing FSM states.
package sd_pkg;

  typedef logic [1:0] sd_digit_t;

  localparam sd_digit_t SD_POS  = 2'b10;
  localparam sd_digit_t SD_NEG  = 2'b01;
  localparam sd_digit_t SD_ZERO = 2'b00;

  typedef enum logic [1:0] {
    SD_IDLE  = 2'd0,
    SD_RUN   = 2'd1,
    SD_DRAIN = 2'd2
  } sd_state_e;

  // One delay-line entry: the digit plus its framing flags.
  typedef struct packed {
    sd_digit_t digit;
    logic      valid;
    logic      last;
  } sd_tap_t;

endpackage

// File: rtl/sd_delay_line.sv
// Parametrised shift register with asynchronous active-low clear; output is
// the oldest stage, so an entry emerges DEPTH clocks after it is pushed.
module sd_delay_line #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/sdvm_pipe.sv
// Signed-digit vector multiplexer: scales a plus/minus operand vector by a
// delayed radix-2 digit. Optional SDVM_OUT_REG_EN registers the output stage.
module sdvm_pipe
  import sd_pkg::*;
#(
  parameter int unsigned W          = 4,
  parameter int unsigned DELAY      = 1,
  parameter int unsigned NUM_DIGITS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         digit_valid,
  input  logic [1:0]   digit_select,
  input  logic [W-1:0] vec_in_plus,
  input  logic [W-1:0] vec_in_minus,
  output logic [W-1:0] vec_out_plus,
  output logic [W-1:0] vec_out_minus,
  output logic         out_valid,
  output logic         out_last,
  output logic         busy
);

  localparam int unsigned CW = $clog2(NUM_DIGITS + 1);
`ifdef SDVM_OUT_REG_EN
  localparam int unsigned DRAIN_LEN = DELAY + 1;
`else
  localparam int unsigned DRAIN_LEN = DELAY;
`endif
  localparam int unsigned DCW = $clog2(DRAIN_LEN + 1);

  sd_state_e      state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic [DCW-1:0] dcnt, dcnt_nx;
  logic           is_last;
  sd_tap_t        push, tap;
  logic [W-1:0]   sel_plus, sel_minus;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SD_IDLE;
      cnt   <= '0;
      dcnt  <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      dcnt  <= dcnt_nx;
      busy  <= (state_nx != SD_IDLE);
    end
  end

  // Framing FSM: counts accepted digits, then waits for the line to empty.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    dcnt_nx  = dcnt;
    push     = '0;
    is_last  = (cnt == CW'(NUM_DIGITS - 1));
    case (state)
      SD_IDLE: begin
        if (start) begin
          state_nx = SD_RUN;
          cnt_nx   = '0;
        end
      end
      SD_RUN: begin
        if (digit_valid) begin
          push.digit = digit_select;
          push.valid = 1'b1;
          push.last  = is_last;
          cnt_nx     = cnt + CW'(1);
          if (is_last) begin
            state_nx = SD_DRAIN;
            dcnt_nx  = '0;
          end
        end
      end
      SD_DRAIN: begin
        if (dcnt == DCW'(DRAIN_LEN - 1)) state_nx = SD_IDLE;
        else                             dcnt_nx  = dcnt + DCW'(1);
      end
      default: state_nx = SD_IDLE;
    endcase
  end

  sd_delay_line #(
    .WIDTH ($bits(sd_tap_t)),
    .DEPTH (DELAY)
  ) u_line (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (push),
    .dout  (tap)
  );

  // Negation is a rail swap; zero digits and bubbles give an all-zero vector.
  always_comb begin
    sel_plus  = '0;
    sel_minus = '0;
    if (tap.valid) begin
      case (tap.digit)
        SD_POS: begin
          sel_plus  = vec_in_plus;
          sel_minus = vec_in_minus;
        end
        SD_NEG: begin
          sel_plus  = vec_in_minus;
          sel_minus = vec_in_plus;
        end
        default: begin
          sel_plus  = '0;
          sel_minus = '0;
        end
      endcase
    end
  end

`ifdef SDVM_OUT_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_out_plus  <= '0;
      vec_out_minus <= '0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
    end else begin
      vec_out_plus  <= sel_plus;
      vec_out_minus <= sel_minus;
      out_valid     <= tap.valid;
      out_last      <= tap.valid & tap.last;
    end
  end
`else
  assign vec_out_plus  = sel_plus;
  assign vec_out_minus = sel_minus;
  assign out_valid     = tap.valid;
  assign out_last      = tap.valid & tap.last;
`endif

endmodule

// File: tb/tb_sdvm_pipe.sv
// Self-checking bench for sdvm_pipe: directed steps plus random traffic
// against a cycle-indexed schedule of expected products.
module tb_sdvm_pipe;

  localparam int unsigned W     = 4;
  localparam int unsigned DELAY = 3;
  localparam int unsigned N     = 8;
`ifdef SDVM_OUT_REG_EN
  localparam int REG = 1;
`else
  localparam int REG = 0;
`endif
  localparam int LAT   = int'(DELAY) + REG;
  localparam int DRAIN = int'(DELAY) + REG;
  localparam int MAXC  = 2048;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         digit_valid = 1'b0;
  logic [1:0]   digit_select = 2'b00;
  logic [W-1:0] vec_in_plus = '0;
  logic [W-1:0] vec_in_minus = '0;
  logic [W-1:0] vec_out_plus, vec_out_minus;
  logic         out_valid, out_last, busy;

  sdvm_pipe #(.W(W), .DELAY(DELAY), .NUM_DIGITS(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .digit_valid   (digit_valid),
    .digit_select  (digit_select),
    .vec_in_plus   (vec_in_plus),
    .vec_in_minus  (vec_in_minus),
    .vec_out_plus  (vec_out_plus),
    .vec_out_minus (vec_out_minus),
    .out_valid     (out_valid),
    .out_last      (out_last),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int t = 0;

  // Expected-product schedule indexed by output cycle, plus operand history.
  bit           sv [MAXC];
  bit           sl [MAXC];
  logic [1:0]   sd [MAXC];
  logic [W-1:0] hp [MAXC];
  logic [W-1:0] hm [MAXC];

  bit m_busy = 1'b0;
  bit m_run  = 1'b0;
  int m_cnt  = 0;
  int m_idle_at = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  task automatic check(input int c);
    logic [W-1:0] ep, em;
    int src;
    ep = '0;
    em = '0;
    src = c - REG;
    if (sv[c]) begin
      if (sd[c] == 2'b10) begin
        ep = hp[src]; em = hm[src];
      end else if (sd[c] == 2'b01) begin
        ep = hm[src]; em = hp[src];
      end
    end
    chk("vec_out_plus",  32'(vec_out_plus),  32'(ep));
    chk("vec_out_minus", 32'(vec_out_minus), 32'(em));
    chk("out_valid",     32'(out_valid),     32'(sv[c]));
    chk("out_last",      32'(out_last),      32'(sv[c] & sl[c]));
    chk("busy",          32'(busy),          32'(m_busy));
  endtask

  // Rules of a multiplication: start only when idle, N digits counted,
  // busy held until the line has drained.
  task automatic model_advance(input int c);
    bit nb;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_run  = 1'b0;
      return;
    end
    nb = m_busy;
    if (!m_busy) begin
      if (start) begin
        m_run = 1'b1; m_cnt = 0; nb = 1'b1;
      end
    end else if (m_run) begin
      if (digit_valid) begin
        sv[c + LAT] = 1'b1;
        sd[c + LAT] = digit_select;
        sl[c + LAT] = (m_cnt == int'(N) - 1);
        m_cnt++;
        if (m_cnt == int'(N)) begin
          m_run = 1'b0;
          m_idle_at = c + 1 + DRAIN;
        end
      end
    end else begin
      nb = (c + 1 < m_idle_at);
    end
    m_busy = nb;
  endtask

  task automatic step(input logic s, input logic dv, input logic [1:0] d,
                      input logic [W-1:0] p, input logic [W-1:0] m);
    @(posedge clk);
    t++;
    #1;
    start = s; digit_valid = dv; digit_select = d;
    vec_in_plus = p; vec_in_minus = m;
    hp[t] = p; hm[t] = m;
    #3;
    check(t);
    model_advance(t);
  endtask

  task automatic rand_step(input int start_odds);
    step(1'($urandom_range(0, start_odds - 1) == 0), 1'($urandom_range(0, 3) != 0),
         2'($urandom), W'($urandom), W'($urandom));
  endtask

  initial begin
    for (int i = 0; i < MAXC; i++) begin
      sv[i] = 1'b0; sl[i] = 1'b0; sd[i] = 2'b00; hp[i] = '0; hm[i] = '0;
    end

    // Reset held for a few cycles.
    repeat (3) step(1'b0, 1'b0, 2'b00, '0, '0);
    #2 rst_n = 1'b1;

    // Full multiplication with fixed vectors: +1, -1, 00, 11, then +1s,
    // a 9th digit and a start during drain that must both be ignored.
    step(1'b1, 1'b1, 2'b10, 4'b1010, 4'b0001);
    step(1'b0, 1'b1, 2'b10, 4'b1010, 4'b0001);
    step(1'b0, 1'b1, 2'b01, 4'b1010, 4'b0001);
    step(1'b0, 1'b1, 2'b00, 4'b1010, 4'b0001);
    step(1'b0, 1'b1, 2'b11, 4'b1010, 4'b0001);
    repeat (4) step(1'b0, 1'b1, 2'b10, 4'b1010, 4'b0001);
    step(1'b1, 1'b1, 2'b01, 4'b1010, 4'b0001);
    step(1'b1, 1'b0, 2'b00, 4'b1010, 4'b0001);
    repeat (6) step(1'b0, 1'b0, 2'b00, 4'b1010, 4'b0001);

    // Bubbles inside a run.
    step(1'b1, 1'b0, 2'b00, 4'b0110, 4'b1001);
    step(1'b0, 1'b1, 2'b10, 4'b0110, 4'b1001);
    step(1'b0, 1'b0, 2'b01, 4'b0110, 4'b1001);
    step(1'b0, 1'b1, 2'b01, 4'b0110, 4'b1001);
    repeat (20) step(1'b0, 1'b0, 2'b00, 4'b0110, 4'b1001);
    repeat (6) step(1'b0, 1'b1, 2'b10, 4'b0011, 4'b1100);
    repeat (6) step(1'b0, 1'b0, 2'b00, 4'b0011, 4'b1100);

    // Random traffic.
    repeat (600) rand_step(8);

    // Mid-run asynchronous reset.
    step(1'b0, 1'b0, 2'b00, '0, '0);
    while (m_busy && t < 1900) step(1'b0, 1'b1, 2'b10, 4'hF, 4'h0);
    step(1'b1, 1'b1, 2'b10, 4'h5, 4'hA);
    repeat (5) step(1'b0, 1'b1, 2'b01, 4'h5, 4'hA);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_plus",  32'(vec_out_plus),  32'd0);
    chk("rst_out_minus", 32'(vec_out_minus), 32'd0);
    chk("rst_out_valid", 32'(out_valid),     32'd0);
    chk("rst_out_last",  32'(out_last),      32'd0);
    chk("rst_busy",      32'(busy),          32'd0);
    m_busy = 1'b0;
    m_run  = 1'b0;
    for (int i = t + 1; i < MAXC; i++) begin
      sv[i] = 1'b0; sl[i] = 1'b0;
    end
    repeat (2) step(1'b0, 1'b1, 2'b10, 4'h5, 4'hA);
    #2 rst_n = 1'b1;
    // Digits without a start must produce nothing.
    repeat (10) step(1'b0, 1'b1, 2'b10, 4'h5, 4'hA);
    repeat (150) rand_step(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
